// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the multi-cycle serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Step counter width; a single-step configuration still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bor_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bor_out;
  logic             ovf;

  modport master (
    output start, a, b, bor_in,
    input  busy, done, diff, bor_out, ovf
  );

  modport slave (
    input  start, a, b, bor_in,
    output busy, done, diff, bor_out, ovf
  );
endinterface

// File: rtl/serial_subtractor_fs_slice.sv
// Combinational BPC-bit ripple-borrow subtractor slice built from full-subtractor cells.
module fs_slice #(
  parameter int unsigned BPC = 1
) (
  input  logic [BPC-1:0] i_a,
  input  logic [BPC-1:0] i_b,
  input  logic           i_bin,
  output logic [BPC-1:0] o_d,
  output logic           o_bout,
  output logic           o_bmsb
);

  logic [BPC:0] w_c;

  assign w_c[0] = i_bin;

  for (genvar k = 0; k < BPC; k++) begin : g_bit
    assign o_d[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
    assign w_c[k+1] = (~i_a[k] & i_b[k]) | (~(i_a[k] ^ i_b[k]) & w_c[k]);
  end

  assign o_bout = w_c[BPC];
  // Borrow entering the top bit; on the last step this is the borrow into the word MSB.
  assign o_bmsb = w_c[BPC-1];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bor_in, BPC bits per clock, LSB slice first, with signed-overflow flag.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / BPC;
  localparam int unsigned CW    = cnt_w(STEPS);

  if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_param_check
    $error("serial_subtractor: BPC must divide WIDTH and WIDTH must be >= 2");
  end

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_bor;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor_out;
  logic             r_ovf;
  logic             r_done;

  logic [BPC-1:0]   w_d;
  logic             w_bout;
  logic             w_bmsb;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  fs_slice #(.BPC(BPC)) u_slice (
    .i_a    (r_a[BPC-1:0]),
    .i_b    (r_b[BPC-1:0]),
    .i_bin  (r_bor),
    .o_d    (w_d),
    .o_bout (w_bout),
    .o_bmsb (w_bmsb)
  );

  // New difference bits enter at the MSB end so the word is aligned after STEPS shifts.
  assign w_res_next = (r_res >> BPC) | (WIDTH'(w_d) << (WIDTH - BPC));
  assign w_last     = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_bor     <= 1'b0;
      r_res     <= '0;
      r_diff    <= '0;
      r_bor_out <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_bor   <= bus.bor_in;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> BPC;
          r_b   <= r_b >> BPC;
          r_bor <= w_bout;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          // Outputs are only published once the whole word is assembled.
          if (w_last) begin
            r_diff    <= w_res_next;
            r_bor_out <= w_bout;
            r_ovf     <= w_bmsb ^ w_bout;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state == RUN);
  assign bus.done    = r_done;
  assign bus.diff    = r_diff;
  assign bus.bor_out = r_bor_out;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and reference-model checks of serial_subtractor in three configurations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  if_a ();
  serial_subtractor_if #(.WIDTH(16)) if_b ();
  serial_subtractor_if #(.WIDTH(8))  if_c ();

  serial_subtractor #(.WIDTH(8),  .BPC(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  serial_subtractor #(.WIDTH(16), .BPC(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  serial_subtractor #(.WIDTH(8),  .BPC(8)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bor;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } res_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] last_exp [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic bin);
    case (sel)
      0: begin if_a.start = st; if_a.a = a[7:0]; if_a.b = b[7:0]; if_a.bor_in = bin; end
      1: begin if_b.start = st; if_b.a = a;      if_b.b = b;      if_b.bor_in = bin; end
      default: begin if_c.start = st; if_c.a = a[7:0]; if_c.b = b[7:0]; if_c.bor_in = bin; end
    endcase
  endtask

  task automatic sample(input int sel, output logic bz, output logic dn, output logic [15:0] d,
                        output logic bo, output logic ov);
    case (sel)
      0: begin bz = if_a.busy; dn = if_a.done; d = 16'(if_a.diff); bo = if_a.bor_out; ov = if_a.ovf; end
      1: begin bz = if_b.busy; dn = if_b.done; d = if_b.diff;      bo = if_b.bor_out; ov = if_b.ovf; end
      default: begin bz = if_c.busy; dn = if_c.done; d = 16'(if_c.diff); bo = if_c.bor_out; ov = if_c.ovf; end
    endcase
  endtask

  // Independent arithmetic reference: unsigned borrow and signed range overflow.
  function automatic res_t model(input int unsigned w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bin);
    res_t   r;
    longint ua, ub, full, sa, sb, s, half;
    ua   = longint'(a);
    ub   = longint'(b);
    full = ua - ub - longint'(bin);
    half = 64'sd1 <<< (w - 1);
    sa   = a[w-1] ? ua - (half * 2) : ua;
    sb   = b[w-1] ? ub - (half * 2) : ub;
    s    = sa - sb - longint'(bin);
    r.d  = 16'(full & ((half * 2) - 1));
    r.bo = (full < 0);
    r.ov = (s < -half) || (s > half - 1);
    return r;
  endfunction

  // Start one op from the current (post-edge) time, then track it until done appears.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input int steps, input string tag,
                        output logic [15:0] d, output logic bo, output logic ov);
    logic bz, dn, partial;
    int   lat, nbusy;
    drive(sel, 1'b1, a, b, bin);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~a, ~b, ~bin);
    lat = 0; nbusy = 0; partial = 1'b0;
    sample(sel, bz, dn, d, bo, ov);
    if (bz) nbusy++;
    while (!dn && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      sample(sel, bz, dn, d, bo, ov);
      if (!dn) begin
        if (bz) nbusy++;
        if (d !== last_exp[sel]) partial = 1'b1;
      end
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(steps));
    chk($sformatf("%s busy_cycles", tag), 32'(nbusy), 32'(steps));
    chk($sformatf("%s busy_at_done", tag), 32'(bz), 32'(0));
    chk($sformatf("%s partial_visible", tag), 32'(partial), 32'(0));
  endtask

  initial begin
    vec_t        vecs [10];
    logic        bz, dn, bo, ov;
    logic [15:0] d;
    res_t        m;
    int          n, ndone;
    logic        got;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1};
    vecs[9] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, 1'b1};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 16'h0, 16'h0, 1'b0);
      last_exp[s] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    sample(0, bz, dn, d, bo, ov);
    chk("reset busy", 32'(bz), 0);
    chk("reset done", 32'(dn), 0);
    chk("reset diff", 32'(d), 0);
    chk("reset bor_out", 32'(bo), 0);
    chk("reset ovf", 32'(ov), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: each new start is driven in the previous op's done cycle.
    for (int i = 0; i < 10; i++) begin
      run_op(0, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].bin, 8, $sformatf("vec%0d", i), d, bo, ov);
      chk($sformatf("vec%0d diff", i), 32'(d), 32'(vecs[i].diff));
      chk($sformatf("vec%0d bor_out", i), 32'(bo), 32'(vecs[i].bor));
      chk($sformatf("vec%0d ovf", i), 32'(ov), 32'(vecs[i].ovf));
      last_exp[0] = 16'(vecs[i].diff);
    end
    @(posedge clk); #1;
    sample(0, bz, dn, d, bo, ov);
    chk("done_pulse_width", 32'(dn), 0);
    chk("idle_after_table", 32'(bz), 0);

    // Start held through RUN with operands changing: one result, original operands.
    drive(0, 1'b1, 16'h35, 16'h12, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 16'hAA, 16'h11, 1'b1);
    n = 0; got = 1'b0; ndone = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      sample(0, bz, dn, d, bo, ov);
      if (dn) begin got = 1'b1; ndone++; end
    end
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("hold latency", 32'(n), 8);
    chk("hold diff", 32'(d), 32'h23);
    chk("hold bor_out", 32'(bo), 0);
    @(posedge clk); #1;
    sample(0, bz, dn, d, bo, ov);
    chk("hold single_done", 32'(dn), 0);
    chk("hold idle", 32'(bz), 0);
    last_exp[0] = 16'h23;

    // Reset at the 4th RUN edge abandons the op.
    drive(0, 1'b1, 16'h35, 16'h12, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sample(0, bz, dn, d, bo, ov);
    chk("midrst busy", 32'(bz), 0);
    chk("midrst done", 32'(dn), 0);
    chk("midrst diff", 32'(d), 0);
    chk("midrst bor_out", 32'(bo), 0);
    chk("midrst ovf", 32'(ov), 0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      sample(0, bz, dn, d, bo, ov);
      if (dn || bz) ndone++;
    end
    chk("midrst no_activity", 32'(ndone), 0);
    for (int s = 0; s < 3; s++) last_exp[s] = 16'h0;
    run_op(0, 16'h35, 16'h12, 1'b0, 8, "post_rst", d, bo, ov);
    chk("post_rst diff", 32'(d), 32'h23);
    chk("post_rst bor_out", 32'(bo), 0);
    chk("post_rst ovf", 32'(ov), 0);

    // Random operands against the reference model: WIDTH=16/BPC=4, then WIDTH=8/BPC=8.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      m    = model(16, ra, rb, rbin);
      run_op(1, ra, rb, rbin, 4, $sformatf("w16 #%0d", i), d, bo, ov);
      chk($sformatf("w16 #%0d diff", i), 32'(d), 32'(m.d));
      chk($sformatf("w16 #%0d bor_out", i), 32'(bo), 32'(m.bo));
      chk($sformatf("w16 #%0d ovf", i), 32'(ov), 32'(m.ov));
      last_exp[1] = m.d;
    end
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      ra   = 16'($urandom_range(0, 255));
      rb   = 16'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      m    = model(8, ra, rb, rbin);
      run_op(2, ra, rb, rbin, 1, $sformatf("b8 #%0d", i), d, bo, ov);
      chk($sformatf("b8 #%0d diff", i), 32'(d), 32'(m.d));
      chk($sformatf("b8 #%0d bor_out", i), 32'(bo), 32'(m.bo));
      chk($sformatf("b8 #%0d ovf", i), 32'(ov), 32'(m.ov));
      last_exp[2] = m.d;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
